alu_arbiter: RTL and testbench

Round-robin arbiter that shares one `alu` instance between `NREQ` requesters: the execute stage, and an address/branch-target helper. It accepts one operation per cycle through per-requester valid/ready handshakes. It drives the ALU operand ports combinationally and registers the ALU result into a single-entry response slot, tagged with the requester index. It sits between the decode/issue logic and the ALU in the execute stage.

---
 rtl/alu_arb_pkg.sv | 26 ++
 rtl/alu_arbiter_rr.sv | 45 ++++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Struct field widths follow the default arbiter configuration.
package alu_arb_pkg;

    localparam int ARB_DWIDTH = 32;
    localparam int ARB_AWIDTH = 32;
    localparam int ARB_IDW    = 1;

    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_BASE = 7'b0000000;

    typedef struct packed {
        logic [ARB_AWIDTH-1:0] pc;
        logic [ARB_DWIDTH-1:0] rs1;
        logic [ARB_DWIDTH-1:0] rs2;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
    } alu_req_t;

    typedef struct packed {
        logic [ARB_IDW-1:0]    id;
        logic [ARB_DWIDTH-1:0] res;
        logic                  brtaken;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Round-robin grant generator: one-hot grant starting the scan at ptr,
// ptr moves just past the winner whenever the grant is actually taken.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    int            idx;

    // Scan from the farthest offset down so the nearest valid requester wins last.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                next_ptr   = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters with a single registered response slot.
// Optional performance counters are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int IDW    = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid_i,
    output logic [NREQ-1:0]              req_ready_o,
    input  logic [NREQ-1:0][AWIDTH-1:0]  req_pc_i,
    input  logic [NREQ-1:0][DWIDTH-1:0]  req_rs1_i,
    input  logic [NREQ-1:0][DWIDTH-1:0]  req_rs2_i,
    input  logic [NREQ-1:0][2:0]         req_funct3_i,
    input  logic [NREQ-1:0][6:0]         req_funct7_i,
    output logic [AWIDTH-1:0]            alu_pc_o,
    output logic [DWIDTH-1:0]            alu_rs1_o,
    output logic [DWIDTH-1:0]            alu_rs2_o,
    output logic [2:0]                   alu_funct3_o,
    output logic [6:0]                   alu_funct7_o,
    input  logic [DWIDTH-1:0]            alu_res_i,
    input  logic                         alu_brtaken_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [IDW-1:0]               rsp_id_o,
    output logic [DWIDTH-1:0]            rsp_res_o,
    output logic                         rsp_brtaken_o
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NREQ-1:0][31:0]        perf_accept_cnt_o,
    output logic [31:0]                  perf_stall_cnt_o
`endif
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            can_issue;
    logic            accept;
    logic            slot_valid;
    alu_req_t        sel;
    alu_rsp_t        slot;

    assign can_issue   = !slot_valid || rsp_ready_i;
    assign req_ready_o = (can_issue && !reset) ? grant : '0;
    assign accept      = |(req_ready_o & req_valid_i);

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid_i),
        .advance (accept),
        .grant   (grant)
    );

    // Requester 0 drives the ALU when nobody is granted, keeping the mux deterministic.
    always_comb begin
        sel.pc     = req_pc_i[0];
        sel.rs1    = req_rs1_i[0];
        sel.rs2    = req_rs2_i[0];
        sel.funct3 = req_funct3_i[0];
        sel.funct7 = req_funct7_i[0];
        grant_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.pc     = req_pc_i[i];
                sel.rs1    = req_rs1_i[i];
                sel.rs2    = req_rs2_i[i];
                sel.funct3 = req_funct3_i[i];
                sel.funct7 = req_funct7_i[i];
                grant_idx  = IDW'(i);
            end
        end
    end

    assign alu_pc_o     = sel.pc;
    assign alu_rs1_o    = sel.rs1;
    assign alu_rs2_o    = sel.rs2;
    assign alu_funct3_o = sel.funct3;
    assign alu_funct7_o = sel.funct7;

    // A new accept always overwrites the slot, which also covers drain-and-refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 1'b0;
            slot       <= '0;
        end else if (accept) begin
            slot_valid   <= 1'b1;
            slot.id      <= grant_idx;
            slot.res     <= alu_res_i;
            slot.brtaken <= alu_brtaken_i;
        end else if (rsp_ready_i) begin
            slot_valid <= 1'b0;
        end
    end

    assign rsp_valid_o   = slot_valid;
    assign rsp_id_o      = slot.id;
    assign rsp_res_o     = slot.res;
    assign rsp_brtaken_o = slot.brtaken;

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_accept_cnt_o <= '0;
            perf_stall_cnt_o  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready_o[i] && req_valid_i[i]) begin
                    perf_accept_cnt_o[i] <= perf_accept_cnt_o[i] + 32'd1;
                end
            end
            if (|req_valid_i && !can_issue) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in ALU (ADD/SUB/BLT).
// Perf counter checks are compiled in when ALU_ARB_PERF_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_pc;
    logic [1:0][31:0]  req_rs1;
    logic [1:0][31:0]  req_rs2;
    logic [1:0][2:0]   req_funct3;
    logic [1:0][6:0]   req_funct7;
    logic [31:0]       alu_pc;
    logic [31:0]       alu_rs1;
    logic [31:0]       alu_rs2;
    logic [2:0]        alu_funct3;
    logic [6:0]        alu_funct7;
    logic [31:0]       alu_res;
    logic              alu_brtaken;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_res;
    logic              rsp_brtaken;
`ifdef ALU_ARB_PERF_EN
    logic [1:0][31:0]  perf_accept_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2), .DWIDTH(32), .AWIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_pc_i      (req_pc),
        .req_rs1_i     (req_rs1),
        .req_rs2_i     (req_rs2),
        .req_funct3_i  (req_funct3),
        .req_funct7_i  (req_funct7),
        .alu_pc_o      (alu_pc),
        .alu_rs1_o     (alu_rs1),
        .alu_rs2_o     (alu_rs2),
        .alu_funct3_o  (alu_funct3),
        .alu_funct7_o  (alu_funct7),
        .alu_res_i     (alu_res),
        .alu_brtaken_i (alu_brtaken),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_res_o     (rsp_res),
        .rsp_brtaken_o (rsp_brtaken)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_accept_cnt_o (perf_accept_cnt),
        .perf_stall_cnt_o  (perf_stall_cnt)
`endif
    );

    // Stand-in ALU: ADD/SUB on funct3=000, BLT on funct3=100 (result = pc+4).
    always_comb begin
        alu_res     = '0;
        alu_brtaken = 1'b0;
        case (alu_funct3)
            3'b000: alu_res = (alu_funct7 == F7_ALT) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
            3'b100: begin
                alu_brtaken = $signed(alu_rs1) < $signed(alu_rs2);
                alu_res     = alu_pc + 32'd4;
            end
            default: alu_res = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [2:0] f3, input logic [6:0] f7);
        req_pc[r]     = pc;
        req_rs1[r]    = rs1;
        req_rs2[r]    = rs2;
        req_funct3[r] = f3;
        req_funct7[r] = f7;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        set_req(0, 32'h0, 32'd1, 32'd2, 3'b000, F7_BASE);
        set_req(1, 32'h0, 32'd0, 32'd0, 3'b000, F7_BASE);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 00", req_ready);
        end
        tick();
        tick();
        reset     = 1'b0;
        req_valid = 2'b00;
        checks++;
        if ({rsp_valid, rsp_id, rsp_brtaken} !== 3'b000 || rsp_res !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got valid=%b id=%0d br=%b res=%h expected all zero",
                     rsp_valid, rsp_id, rsp_brtaken, rsp_res);
        end
    endtask

    task automatic test_basic_add();
        set_req(0, 32'h0, 32'd5, 32'd7, 3'b000, F7_BASE);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL add_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_res !== 32'd12 || rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_rsp: got valid=%b res=%h id=%0d expected 1/0000000c/0",
                     rsp_valid, rsp_res, rsp_id);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_drain: got valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready [4];
        logic [31:0] exp_res   [4];
        exp_ready = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_res   = '{32'd30, 32'hFFFF_FFFE, 32'd30, 32'hFFFF_FFFE};
        do_reset();
        set_req(0, 32'h0, 32'd10, 32'd20, 3'b000, F7_BASE);
        set_req(1, 32'h0, 32'd3,  32'd5,  3'b000, F7_ALT);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== exp_ready[k]) begin
                errors++;
                $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready[k]);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(k % 2) || rsp_res !== exp_res[k]) begin
                errors++;
                $display("[TB] FAIL rr_rsp[%0d]: got valid=%b id=%0d res=%h expected 1/%0d/%h",
                         k, rsp_valid, rsp_id, rsp_res, k % 2, exp_res[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_ready_now: got %b expected 00", req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 32'hFFFF_FFFE ||
                rsp_brtaken !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b id=%0d res=%h br=%b ready=%b expected 1/1/fffffffe/0/00",
                         k, rsp_valid, rsp_id, rsp_res, rsp_brtaken, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_release_ready: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd30) begin
            errors++;
            $display("[TB] FAIL bp_refill: got valid=%b id=%0d res=%h expected 1/0/0000001e",
                     rsp_valid, rsp_id, rsp_res);
        end
        tick();
    endtask

    task automatic test_branch();
        set_req(1, 32'h100, 32'hFFFF_FFFF, 32'd1, 3'b100, F7_BASE);
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL br_ready: got %b expected 10", req_ready);
        end
        tick();
        checks++;
        if (rsp_brtaken !== 1'b1 || rsp_id !== 1'b1 || rsp_res !== 32'h104) begin
            errors++;
            $display("[TB] FAIL br_taken: got br=%b id=%0d res=%h expected 1/1/00000104",
                     rsp_brtaken, rsp_id, rsp_res);
        end
        set_req(1, 32'h200, 32'd1, 32'hFFFF_FFFF, 3'b100, F7_BASE);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL br_single_ready: got %b expected 10", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_brtaken !== 1'b0 || rsp_id !== 1'b1 || rsp_res !== 32'h204) begin
            errors++;
            $display("[TB] FAIL br_not_taken: got br=%b id=%0d res=%h expected 0/1/00000204",
                     rsp_brtaken, rsp_id, rsp_res);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(0, 32'h0, 32'd5, 32'd7, 3'b000, F7_BASE);
        set_req(1, 32'h0, 32'd3, 32'd5, 3'b000, F7_ALT);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        tick();
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rmid_ready: got %b expected 00", req_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_res !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rmid_flush: got valid=%b res=%h expected 0/00000000", rsp_valid, rsp_res);
        end
        reset     = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rmid_first_grant: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_res !== 32'd12) begin
            errors++;
            $display("[TB] FAIL rmid_rsp: got valid=%b id=%0d res=%h expected 1/0/0000000c",
                     rsp_valid, rsp_id, rsp_res);
        end
        tick();
    endtask

`ifdef ALU_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        set_req(0, 32'h0, 32'd1, 32'd1, 3'b000, F7_BASE);
        set_req(1, 32'h0, 32'd2, 32'd2, 3'b000, F7_BASE);
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) tick();
        req_valid = 2'b10;
        for (int k = 0; k < 2; k++) tick();
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        req_valid = 2'b00;
        checks++;
        if (perf_accept_cnt[0] !== 32'd4 || perf_accept_cnt[1] !== 32'd2 || perf_stall_cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL perf_counts: got acc0=%0d acc1=%0d stall=%0d expected 4/2/3",
                     perf_accept_cnt[0], perf_accept_cnt[1], perf_stall_cnt);
        end
        rsp_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_round_robin();
        test_backpressure();
        test_branch();
        test_reset_mid();
`ifdef ALU_ARB_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
